// File: rtl/combo_tracker.sv
// combo_tracker: combo counter, milestone launch FSM and frame phase source
// for the combo sprite animator, clocked on frame_clk.
// Optional build macro: COMBO_BCD_EN adds a registered three-digit BCD mirror
// of combo_count on combo_bcd; when undefined combo_bcd is tied to zero.
module combo_tracker #(
  parameter int unsigned MILESTONE = 10,
  parameter int unsigned FRAME_DIV = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       hit,
  input  logic       miss,
  input  logic       keep_on,
  input  logic       audio_flag1,
  output logic       BallEN,
  output logic [3:0] frame,
  output logic [9:0] combo_count,
  output logic [9:0] max_combo,
  output logic       sfx_pulse,
  output logic [11:0] combo_bcd
);

  typedef enum logic [1:0] {IDLE, LAUNCH, ANIMATE, DRAIN} state_t;

  localparam logic [9:0] COMBO_MAX = 10'd999;
  localparam logic [5:0] MS_LAST   = 6'(MILESTONE - 1);
  localparam logic [7:0] DIV_LAST  = 8'(FRAME_DIV - 1);

  state_t     state, state_next;
  logic [5:0] ms_cnt, ms_next;
  logic       pending, pending_clr, milestone;
  logic [9:0] combo_next;
  logic [7:0] div_cnt, div_next;
  logic [3:0] frame_next;
  logic       af_q, af_d;

  // Combo and milestone next values; miss dominates a coincident hit
  always_comb begin
    combo_next = combo_count;
    ms_next    = ms_cnt;
    milestone  = 1'b0;
    if (miss) begin
      combo_next = '0;
      ms_next    = '0;
    end else if (hit) begin
      if (combo_count != COMBO_MAX)
        combo_next = combo_count + 10'd1;
      if (ms_cnt == MS_LAST) begin
        ms_next   = '0;
        milestone = 1'b1;
      end else begin
        ms_next = ms_cnt + 6'd1;
      end
    end
  end

  // Combo, best combo, milestone counter and pending launch flag
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      combo_count <= '0;
      max_combo   <= '0;
      ms_cnt      <= '0;
      pending     <= 1'b0;
    end else begin
      combo_count <= combo_next;
      if (combo_next > max_combo)
        max_combo <= combo_next;
      ms_cnt <= ms_next;
      // a milestone arriving as the FSM consumes pending is kept, not lost
      if (milestone)
        pending <= 1'b1;
      else if (pending_clr)
        pending <= 1'b0;
    end
  end

  // Launch FSM next state, frame phase and divider
  always_comb begin
    state_next  = state;
    frame_next  = '0;
    div_next    = '0;
    pending_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending) begin
          state_next  = LAUNCH;
          pending_clr = 1'b1;
        end
      end
      LAUNCH: begin
        if (keep_on)
          state_next = ANIMATE;
      end
      ANIMATE: begin
        if (!keep_on) begin
          state_next = DRAIN;
        end else if (div_cnt == DIV_LAST) begin
          div_next   = '0;
          frame_next = (frame == 4'hF) ? frame : frame + 4'd1;
        end else begin
          div_next   = div_cnt + 8'd1;
          frame_next = frame;
        end
      end
      DRAIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register; BallEN trails the LAUNCH state by one clock
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state   <= IDLE;
      frame   <= '0;
      div_cnt <= '0;
      BallEN  <= 1'b0;
    end else begin
      state   <= state_next;
      frame   <= frame_next;
      div_cnt <= div_next;
      BallEN  <= (state == LAUNCH);
    end
  end

  // Audio flag is sampled once, then edge-detected against its delayed copy
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      af_q      <= 1'b0;
      af_d      <= 1'b0;
      sfx_pulse <= 1'b0;
    end else begin
      af_q      <= audio_flag1;
      af_d      <= af_q;
      sfx_pulse <= af_q & ~af_d;
    end
  end

`ifdef COMBO_BCD_EN
  logic [11:0] bcd_mirror, bcd_inc, bcd_q;

  // Decimal +1 on the mirror; only used below 999
  always_comb begin
    bcd_inc = bcd_mirror;
    if (bcd_mirror[3:0] != 4'd9) begin
      bcd_inc[3:0] = bcd_mirror[3:0] + 4'd1;
    end else begin
      bcd_inc[3:0] = 4'd0;
      if (bcd_mirror[7:4] != 4'd9) begin
        bcd_inc[7:4] = bcd_mirror[7:4] + 4'd1;
      end else begin
        bcd_inc[7:4]  = 4'd0;
        bcd_inc[11:8] = bcd_mirror[11:8] + 4'd1;
      end
    end
  end

  // BCD mirror tracks combo_count; output stage adds one clock of latency
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      bcd_mirror <= '0;
      bcd_q      <= '0;
    end else begin
      if (miss)
        bcd_mirror <= '0;
      else if (hit && bcd_mirror != 12'h999)
        bcd_mirror <= bcd_inc;
      bcd_q <= bcd_mirror;
    end
  end

  assign combo_bcd = bcd_q;
`else
  assign combo_bcd = '0;
`endif

endmodule

// File: doc/combo_tracker.md
# combo_tracker

Rhythm-game combo judge and launch controller; the upstream driver of the combo sprite animator. It counts consecutive judged hits and raises a launch request (`BallEN`) every `MILESTONE` hits. While the animator runs, it supplies the animator's 4-bit `frame` phase and turns the animator's audio flag into a one-cycle sound-effect pulse. Sits between the hit-judgement logic and the combo animator, clocked on the frame clock.

## Interface

- `MILESTONE`, default 10: consecutive hits per launch; legal range 2..63.
- `FRAME_DIV`, default 4: clocks per `frame` increment while animating; legal range 1..255.
- `frame_clk` input 1: sole clock, rising-edge.
- `Reset` input 1: synchronous, active-high.
- `hit` input 1: one-cycle pulse, judged hit.
- `miss` input 1: one-cycle pulse, judged miss.
- `keep_on` input 1: animator busy, from the animator.
- `audio_flag1` input 1: animator audio flag, level.
- `BallEN` output 1: launch request to the animator.
- `frame` output 4: animation phase to the animator.
- `combo_count` output 10: current consecutive hits, saturates at 999.
- `max_combo` output 10: highest `combo_count` since reset.
- `sfx_pulse` output 1: one-cycle pulse per rising edge of `audio_flag1`.
- `combo_bcd` output 12: three BCD digits of `combo_count` (see Configuration).

## Operation

- Counting:
  - `hit` increments `combo_count`, saturating at 999.
  - `miss` clears `combo_count` to 0.
  - `hit` and `miss` in the same cycle: miss wins.
  - `max_combo` loads `combo_count`'s new value whenever that value exceeds `max_combo`.
- Milestones:
  - A 6-bit modulo counter `ms_cnt` tracks hits; it is cleared by `miss`.
  - A `hit` with `ms_cnt == MILESTONE-1` wraps `ms_cnt` to 0 and sets the `pending` flag.
  - Hits while `combo_count` is at saturation still advance `ms_cnt`.
  - `pending` is a single flag: milestones reached while `pending` is already set coalesce into one launch.
  - `miss` does not clear `pending`.
- FSM states: IDLE, LAUNCH, ANIMATE, DRAIN.
  - IDLE: if `pending` is set, go to LAUNCH and clear `pending`.
  - LAUNCH: `BallEN` = 1. When `keep_on` is sampled 1, go to ANIMATE with `frame` = 0 and the divider = 0.
  - ANIMATE: divider counts 0..`FRAME_DIV`-1. On wrap, `frame` increments, saturating at 15. When `keep_on` is sampled 0, go to DRAIN.
  - DRAIN: `frame` returns to 0. Next cycle go to IDLE unconditionally.
- `BallEN` is registered and equals (state == LAUNCH). It is held until `keep_on` is seen; there is no timeout.
- `frame` is 0 in every state except ANIMATE.
- `sfx_pulse` is registered: `audio_flag1` & ~`audio_flag1_d`, where `audio_flag1_d` is `audio_flag1` delayed by one clock.

## Timing

- Reset value of every output is 0. Reset also forces state = IDLE and clears `pending`, `ms_cnt`, the divider and `audio_flag1_d`.
- Reset asserted mid-operation aborts any launch or animation in the same cycle.
- Count latency: `hit` or `miss` sampled at edge k → `combo_count` and `max_combo` valid after edge k; `combo_bcd` valid after edge k+1.
- Launch latency from IDLE: milestone `hit` at edge k → `pending` set at k → state LAUNCH at k+1 → `BallEN` high after edge k+2.
- Launch handshake: `keep_on` sampled 1 at edge j → `BallEN` low after edge j+1.
- Frame cadence: the first `frame` increment occurs `FRAME_DIV` edges after ANIMATE entry. `frame` reaches 14 after 14·`FRAME_DIV` edges.
- `sfx_pulse`: `audio_flag1` rising, sampled at edge k → `sfx_pulse` high for exactly the cycle after edge k+1.
- A milestone landing during ANIMATE or DRAIN is served right after DRAIN: DRAIN → IDLE → LAUNCH.

## Configuration

- `COMBO_BCD_EN` defined:
  - A three-digit BCD counter mirrors `combo_count` incrementally: +1 with decimal carry, cleared by `miss`, frozen at 999.
  - The mirror is registered once more onto `combo_bcd`, giving 1-cycle extra latency.
- `COMBO_BCD_EN` undefined: the BCD logic is omitted and `combo_bcd` is tied to 12'h000.

## Test plan

- Reset, then 9 `hit` pulses → `combo_count` = 9, `BallEN` stays 0. 10th hit → `BallEN` = 1 exactly 2 edges later and held. `keep_on` = 1 → `BallEN` = 0 one edge after it is sampled.
- With `FRAME_DIV` = 4, hold `keep_on` = 1 for 80 cycles → `frame` steps every 4 clocks, reads 14 at clock 56, saturates at 15. Drop `keep_on` → `frame` = 0, state IDLE two edges later.
- 25 hits, then `hit` and `miss` in the same cycle → `combo_count` = 0, `max_combo` = 25. Next hit → `combo_count` = 1.
- 20 hits during one animation → exactly one additional `BallEN` assertion after DRAIN, not two.
- Toggle `audio_flag1` 0→1 and hold for 10 cycles → `sfx_pulse` high for exactly 1 cycle. Assert `Reset` during LAUNCH → all outputs 0 on the next edge, `pending` cleared.
- With `COMBO_BCD_EN`, 1005 hits → `combo_count` = 999, `combo_bcd` = 12'h999. Without `COMBO_BCD_EN` → `combo_bcd` = 12'h000 throughout.
